// File: rtl/ofifo_param.sv
// Output FIFO between PE-array columns and the psum/SFU read path. Each column
// is written on its own; reads pop one aligned row across all columns.
module ofifo_param #(
  parameter int col      = 8,
  parameter int psum_bw  = 16,
  parameter int depth    = 64,
  parameter int afull_th = 60
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [col-1:0]             wr,
  input  logic [psum_bw*col-1:0]     in,
  input  logic                       rd,
  output logic [psum_bw*col-1:0]     out,
  output logic                       o_out_valid,
  output logic                       o_full,
  output logic                       o_afull,
  output logic                       o_ready,
  output logic                       o_valid,
  output logic [$clog2(depth):0]     o_level,
  output logic                       o_err_ovf,
  output logic                       o_err_udf
);

  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;

  typedef logic [PW-1:0] ptr_t;

  ptr_t           rptr;
  ptr_t           cnt [col];
  logic [col-1:0] col_full;
  logic [col-1:0] col_afull;
  logic [col-1:0] col_nempty;
  logic [col-1:0] ovf_hit;
  logic           pop;

  assign pop = rd && o_valid;

  for (genvar g = 0; g < col; g++) begin : g_col
    logic [psum_bw-1:0] mem [depth];
    logic [psum_bw-1:0] row_q;
    ptr_t               wptr;
    logic               wr_ok;

    // The wrap bit makes wptr - rptr an exact count in 0..depth.
    assign cnt[g]        = wptr - rptr;
    assign col_full[g]   = (cnt[g] == ptr_t'(depth));
    assign col_afull[g]  = (cnt[g] >= ptr_t'(afull_th));
    assign col_nempty[g] = (cnt[g] != '0);
    assign wr_ok         = wr[g] && !col_full[g];
    assign ovf_hit[g]    = wr[g] && col_full[g];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
      if (reset)      wptr <= '0;
      else if (wr_ok) wptr <= wptr + 1'b1;
    end

    // NOTE: the storage array is deliberately not reset; pointers alone define
    // which entries are live, so reset only needs to clear them.
    always_ff @(posedge clk) begin
      if (!reset && wr_ok) mem[wptr[AW-1:0]] <= in[psum_bw*g +: psum_bw];
    end

    always_ff @(posedge clk) begin
      if (reset)    row_q <= '0;
      else if (pop) row_q <= mem[rptr[AW-1:0]];
    end

    assign out[psum_bw*g +: psum_bw] = row_q;
  end

  assign o_full  = |col_full;
  assign o_afull = |col_afull;
  assign o_ready = col_nempty[col-1];
  assign o_valid = &col_nempty;

  // Complete rows held = the shortest column.
  always_comb begin
    o_level = cnt[0];
    for (int i = 1; i < col; i++) begin
      if (cnt[i] < o_level) o_level = cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr        <= '0;
      o_out_valid <= 1'b0;
      o_err_ovf   <= 1'b0;
      o_err_udf   <= 1'b0;
    end else begin
      o_out_valid <= pop;
      if (pop)        rptr      <= rptr + 1'b1;
      if (|ovf_hit)   o_err_ovf <= 1'b1;
      if (rd && !o_valid) o_err_udf <= 1'b1;
    end
  end

endmodule
